// File: rtl/muldiv8_pkg.sv
// -----------------------------------------------------------------------------
// muldiv8_pkg
// Shared types and constants for the mul/div pin-side sequencer.
//   state_e         : sequencer states (IDLE, START, WAIT, DIV0, HOLD)
//   OP_MUL / OP_DIV : encoding of the operation bit sent to the core
//   DIV0_QUOT       : quotient byte reported for a divide by zero
//   TIMEOUT_RESULT  : result word reported when the core never answers
// -----------------------------------------------------------------------------
package muldiv8_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    WAIT  = 3'd2,
    DIV0  = 3'd3,
    HOLD  = 3'd4
  } state_e;

  localparam logic        OP_MUL         = 1'b0;
  localparam logic        OP_DIV         = 1'b1;
  localparam logic [7:0]  DIV0_QUOT      = 8'hFF;
  localparam logic [15:0] TIMEOUT_RESULT = 16'hFFFF;

endpackage

// File: rtl/muldiv8_strobe_sync.sv
// -----------------------------------------------------------------------------
// muldiv8_strobe_sync
// Brings one asynchronous pin strobe into the clk domain and turns its rising
// edge into a single-cycle pulse. The pulse is masked while the design is not
// selected.
// Ports:
//   clk       in  1  clock
//   rst_n     in  1  asynchronous active-low reset
//   ena_i     in  1  design selected; gates the edge pulse
//   strobe_i  in  1  asynchronous strobe pin
//   rise_o    out 1  one-cycle pulse on a synchronised rising edge
// -----------------------------------------------------------------------------
module muldiv8_strobe_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena_i,
  input  logic strobe_i,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Shift the raw pin through the synchroniser chain; the extra prev_q flop
  // remembers the last synchronised level so a rising edge can be spotted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], strobe_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // The edge pulse is combinational off the chain output so that the
  // consumer updates exactly SYNC_STAGES+1 clocks after the pin rises.
  assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q & ena_i;

endmodule

// File: rtl/muldiv8_io_sequencer.sv
// -----------------------------------------------------------------------------
// muldiv8_io_sequencer
// Pin-side front end for the 8-bit mul/div core. Operands A and B are loaded
// byte-serially from din on ld_a/ld_b strobes, a go strobe launches one core
// operation, and the 16-bit result is returned a byte at a time on dout.
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   ena                 design selected; masks new strobe edges when low
//   din[7:0]            operand byte
//   ld_a, ld_b, go      asynchronous strobes (rising edge acts)
//   op_div              operation, sampled when go is acted on (1 = divide)
//   hi_sel              dout byte select (1 = result[15:8])
//   dout[7:0]           selected result byte
//   busy, done, err     status: in progress / result valid / error on last op
//   core_a, core_b      operands held for the core
//   core_op             operation to the core (1 = divide)
//   core_start          one-cycle launch pulse to the core
//   core_done           one-cycle completion pulse from the core
//   core_result[15:0]   product, or {remainder, quotient}
// -----------------------------------------------------------------------------
module muldiv8_io_sequencer
  import muldiv8_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic [7:0]  din,
  input  logic        ld_a,
  input  logic        ld_b,
  input  logic        go,
  input  logic        op_div,
  input  logic        hi_sel,
  output logic [7:0]  dout,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [7:0]  core_a,
  output logic [7:0]  core_b,
  output logic        core_op,
  output logic        core_start,
  input  logic        core_done,
  input  logic [15:0] core_result
);

  localparam int             TW    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0]  TLAST = TW'(TIMEOUT_CYCLES - 1);

  state_e         state_q;
  logic [7:0]     operandA_q;
  logic [7:0]     operandB_q;
  logic           opDiv_q;
  logic [15:0]    result_q;
  logic           done_q;
  logic           err_q;
  logic           coreStart_q;
  logic           goPend_q;
  logic [TW-1:0]  timer_q;

  logic           ldARise;
  logic           ldBRise;
  logic           goRise;
  logic           loadAny;

  // One synchroniser plus edge detector per control strobe.
  muldiv8_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) uSyncLdA (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena_i    (ena),
    .strobe_i (ld_a),
    .rise_o   (ldARise)
  );

  muldiv8_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) uSyncLdB (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena_i    (ena),
    .strobe_i (ld_b),
    .rise_o   (ldBRise)
  );

  muldiv8_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) uSyncGo (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena_i    (ena),
    .strobe_i (go),
    .rise_o   (goRise)
  );

  assign loadAny = ldARise | ldBRise;

  // Main sequencer. Operand loads and go handling only happen in IDLE/HOLD,
  // so strobes arriving while the core is busy are simply dropped. When a load
  // and a go arrive together, the load wins this cycle and goPend_q replays the
  // go one cycle later so it sees the freshly loaded operand. In WAIT a
  // core_done is checked before the timeout so a last-moment answer is kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      operandA_q  <= 8'h00;
      operandB_q  <= 8'h00;
      opDiv_q     <= OP_MUL;
      result_q    <= 16'h0000;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      coreStart_q <= 1'b0;
      goPend_q    <= 1'b0;
      timer_q     <= '0;
    end else begin
      coreStart_q <= 1'b0;
      goPend_q    <= 1'b0;
      case (state_q)
        IDLE, HOLD: begin
          if (ldARise) begin
            operandA_q <= din;
          end
          if (ldBRise) begin
            operandB_q <= din;
          end
          if (goRise && loadAny) begin
            goPend_q <= 1'b1;
          end else if (goRise || goPend_q) begin
            opDiv_q <= op_div;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            if (op_div == OP_DIV && operandB_q == 8'h00) begin
              state_q <= DIV0;
            end else begin
              state_q     <= START;
              coreStart_q <= 1'b1;
            end
          end
        end
        START: begin
          timer_q <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (core_done) begin
            result_q <= core_result;
            done_q   <= 1'b1;
            state_q  <= HOLD;
          end else if (timer_q == TLAST) begin
            result_q <= TIMEOUT_RESULT;
            err_q    <= 1'b1;
            done_q   <= 1'b1;
            state_q  <= HOLD;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        DIV0: begin
          result_q <= {operandA_q, DIV0_QUOT};
          err_q    <= 1'b1;
          done_q   <= 1'b1;
          state_q  <= HOLD;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Output decode: status straight from registers, dout is a plain byte mux.
  assign busy       = (state_q == START) || (state_q == WAIT);
  assign done       = done_q;
  assign err        = err_q;
  assign core_a     = operandA_q;
  assign core_b     = operandB_q;
  assign core_op    = opDiv_q;
  assign core_start = coreStart_q;
  assign dout       = hi_sel ? result_q[15:8] : result_q[7:0];

endmodule
